// File: rtl/dijkstra_path_tracer_if.sv
// Command, predecessor-write and readback signals of the Dijkstra path tracer.
// The master drives commands and writes; the slave is the tracer itself.
interface dijkstra_path_tracer_if #(
  parameter int unsigned NODE_W = 16
) ();
  logic              pred_we;
  logic [NODE_W-1:0] pred_node;
  logic [NODE_W-1:0] pred_value;
  logic              start;
  logic [NODE_W-1:0] src;
  logic [NODE_W-1:0] dst;
  logic              busy;
  logic              done;
  logic              path_valid;
  logic [1:0]        error_code;
  logic [NODE_W-1:0] path_len;
  logic [NODE_W-1:0] rd_index;
  logic [NODE_W-1:0] path_node;

  modport master (
    output pred_we, pred_node, pred_value, start, src, dst, rd_index,
    input  busy, done, path_valid, error_code, path_len, path_node
  );

  modport slave (
    input  pred_we, pred_node, pred_value, start, src, dst, rd_index,
    output busy, done, path_valid, error_code, path_len, path_node
  );
endinterface

// File: rtl/dijkstra_path_tracer.sv
// Walks the predecessor array from dst back to src into a path buffer and serves indexed readback.
// Define DIJKSTRA_PATH_FORWARD_EN to read the path src-first instead of dst-first.
module dijkstra_path_tracer #(
  parameter int unsigned MAX_NODES = 32,
  parameter int unsigned NODE_W    = 16
) (
  input logic                   clock,
  input logic                   reset,
  dijkstra_path_tracer_if.slave bus
);
  localparam int unsigned       IdxW     = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam logic [NODE_W-1:0] MaxNodes = NODE_W'(MAX_NODES);
  localparam logic [NODE_W-1:0] Invalid  = '1;

  localparam logic [1:0] ErrNone   = 2'd0;
  localparam logic [1:0] ErrRange  = 2'd1;
  localparam logic [1:0] ErrUnreach = 2'd2;
  localparam logic [1:0] ErrLoop   = 2'd3;

  typedef enum logic [1:0] {StIdle, StTrace, StDone} state_e;

  state_e            state_q, state_d;
  logic [NODE_W-1:0] pred_q [MAX_NODES];
  logic [NODE_W-1:0] pred_d [MAX_NODES];
  logic [NODE_W-1:0] path_buf_q [MAX_NODES];
  logic [NODE_W-1:0] path_buf_d [MAX_NODES];
  logic [NODE_W-1:0] src_q, src_d;
  logic [NODE_W-1:0] cur_q, cur_d;
  logic [NODE_W-1:0] len_q, len_d;
  logic [NODE_W-1:0] path_len_q, path_len_d;
  logic [NODE_W-1:0] path_node_q, path_node_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [1:0]        err_q, err_d;
  logic [NODE_W-1:0] pred_cur;
  logic [IdxW-1:0]   rd_addr;

  assign pred_cur = pred_q[IdxW'(cur_q)];

  always_comb begin
    state_d    = state_q;
    pred_d     = pred_q;
    path_buf_d = path_buf_q;
    src_d      = src_q;
    cur_d      = cur_q;
    len_d      = len_q;
    path_len_d = path_len_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.pred_we && (bus.pred_node < MaxNodes)) begin
          pred_d[IdxW'(bus.pred_node)] = bus.pred_value;
        end
        if (bus.start) begin
          src_d   = bus.src;
          cur_d   = bus.dst;
          len_d   = '0;
          valid_d = 1'b0;
          err_d   = ErrNone;
          busy_d  = 1'b1;
          if ((bus.src >= MaxNodes) || (bus.dst >= MaxNodes)) begin
            err_d   = ErrRange;
            state_d = StDone;
          end else begin
            state_d = StTrace;
          end
        end
      end
      StTrace: begin
        path_buf_d[IdxW'(len_q)] = cur_q;
        len_d = len_q + 1'b1;
        // Reaching src wins over the loop bound so a full-length path still succeeds.
        if (cur_q == src_q) begin
          valid_d = 1'b1;
          state_d = StDone;
        end else if ((len_q + 1'b1) == MaxNodes) begin
          err_d   = ErrLoop;
          state_d = StDone;
        end else if ((pred_cur == Invalid) || (pred_cur >= MaxNodes)) begin
          err_d   = ErrUnreach;
          state_d = StDone;
        end else begin
          cur_d = pred_cur;
        end
      end
      StDone: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        path_len_d = len_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
`ifdef DIJKSTRA_PATH_FORWARD_EN
    rd_addr = IdxW'(path_len_q - 1'b1 - bus.rd_index);
`else
    rd_addr = IdxW'(bus.rd_index);
`endif
    path_node_d = (bus.rd_index < path_len_q) ? path_buf_q[rd_addr] : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      src_q       <= '0;
      cur_q       <= '0;
      len_q       <= '0;
      path_len_q  <= '0;
      path_node_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= ErrNone;
      for (int i = 0; i < MAX_NODES; i++) begin
        pred_q[i]     <= Invalid;
        path_buf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      cur_q       <= cur_d;
      len_q       <= len_d;
      path_len_q  <= path_len_d;
      path_node_q <= path_node_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      pred_q      <= pred_d;
      path_buf_q  <= path_buf_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.path_valid = valid_q;
  assign bus.error_code = err_q;
  assign bus.path_len   = path_len_q;
  assign bus.path_node  = path_node_q;

endmodule
